// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the carry-lookahead arithmetic blocks.
//   DIGIT_W      width of one lookahead digit (4 bits)
//   sub_state_t  control states of the sequential subtractor
//   clog2()      ceiling log2 for sizing counters (never returns less than 1)
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Width needed to count 0..value-1. A one-bit minimum keeps the counter
    // declaration legal even for a single-digit datapath.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage : cla_pkg

// File: rtl/sub4_cla_slice.sv
// ---------------------------------------------------------------------------
// sub4_cla_slice
// One 4-bit carry-lookahead digit computing a4 + ~b4 + cin (a subtract step
// where cin is the inverted borrow).
// Ports:
//   a4    in   4  minuend digit
//   b4    in   4  subtrahend digit (inverted internally)
//   cin   in   1  carry in (= ~borrow in)
//   s4    out  4  difference digit
//   cout  out  1  carry out of bit 3 (= ~borrow out)
//   c3    out  1  carry into bit 3, used for signed overflow on the MSB digit
// ---------------------------------------------------------------------------
module sub4_cla_slice
    import cla_pkg::*;
(
    input  logic [DIGIT_W-1:0] a4,
    input  logic [DIGIT_W-1:0] b4,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s4,
    output logic               cout,
    output logic               c3
);

    logic [DIGIT_W-1:0] nb;
    logic [DIGIT_W-1:0] p;
    logic [DIGIT_W-1:0] g;
    logic [DIGIT_W:0]   c;

    assign nb = ~b4;
    assign p  = a4 ^ nb;
    assign g  = a4 & nb;

    // Flat lookahead equations: every carry depends only on p/g/cin,
    // so no carry ripples through a previous carry.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s4   = p ^ c[DIGIT_W-1:0];
    assign cout = c[4];
    assign c3   = c[3];

endmodule : sub4_cla_slice

// File: rtl/seq_cla_subtractor.sv
// ---------------------------------------------------------------------------
// seq_cla_subtractor
// Multi-cycle subtractor: diff = (a - b - bin) mod 2^WIDTH, one 4-bit
// lookahead digit per clock, borrow chained between digits in a register.
// Parameters:
//   WIDTH      operand/result width, multiple of 4 and >= 8
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (state IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result valid (state DONE)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  difference
//   bout       out  1      unsigned borrow out (a < b + bin)
//   ovf        out  1      signed overflow
//   zero       out  1      diff == 0
// Accept at edge k gives out_valid after edge k+NDIG; one op per NDIG+2 cycles.
// ---------------------------------------------------------------------------
module seq_cla_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = clog2(NDIG);

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("seq_cla_subtractor: WIDTH must be a multiple of 4 and >= 8");
    end

    sub_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               c_q;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] s_dig;
    logic               dig_cout;
    logic               dig_c3;
    logic               last_dig;
    logic [WIDTH-1:0]   diff_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_dig  = (cnt == CNT_W'(NDIG - 1));

    // The counter selects which digit of the captured operands feeds the slice.
    assign a_dig = a_q[int'(cnt) * DIGIT_W +: DIGIT_W];
    assign b_dig = b_q[int'(cnt) * DIGIT_W +: DIGIT_W];

    sub4_cla_slice u_slice (
        .a4   (a_dig),
        .b4   (b_dig),
        .cin  (c_q),
        .s4   (s_dig),
        .cout (dig_cout),
        .c3   (dig_c3)
    );

    // diff with the current digit merged in; on the last digit this is the
    // complete result, which the zero flag is taken from.
    always_comb begin
        // NOTE: assign a full default first so no path leaves diff_next
        // unassigned, which would otherwise infer a latch.
        diff_next = diff;
        diff_next[int'(cnt) * DIGIT_W +: DIGIT_W] = s_dig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            // NOTE: the operand and carry registers are reset too, even though
            // they are always loaded before use, so nothing in the block ever
            // holds X after reset.
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // sees the pre-edge value of the others regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        c_q   <= ~bin;   // subtract as a + ~b + ~bin
                        cnt   <= '0;
                        state <= CALC;
                    end
                end

                CALC: begin
                    diff <= diff_next;
                    c_q  <= dig_cout;
                    cnt  <= cnt + 1'b1;
                    if (last_dig) begin
                        bout  <= ~dig_cout;
                        ovf   <= dig_c3 ^ dig_cout;
                        zero  <= (diff_next == '0);
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_cla_subtractor

// File: tb/tb_seq_cla_subtractor.sv
// ---------------------------------------------------------------------------
// tb_seq_cla_subtractor
// Self-checking bench for seq_cla_subtractor at WIDTH=16. Expected results
// are computed from plain integer arithmetic, queued at accept time, and
// popped by a monitor when the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_seq_cla_subtractor;

    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    seq_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model in wide integer arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mbin);
        exp_t       e;
        logic [WIDTH:0] full;
        int         sd;
        full   = {1'b0, ma} - {1'b0, mb} - (WIDTH+1)'(mbin);
        sd     = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.diff = full[WIDTH-1:0];
        e.bout = full[WIDTH];
        e.ovf  = (sd > 32767) || (sd < -32768);
        e.zero = (full[WIDTH-1:0] == '0);
        return e;
    endfunction

    // Output monitor: compare on every completed handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("bout", 32'(bout), 32'(e.bout));
                check("ovf",  32'(ovf),  32'(e.ovf));
                check("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    // One full transaction. stall holds out_ready low in DONE for that many
    // cycles; poke drives a competing in_valid during CALC; rnd_ready makes
    // out_ready random until the handshake completes.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tbin, input int stall, input bit poke,
                         input bit rnd_ready);
        exp_t e;
        int   n;
        int   lat;
        e = model(ta, tb, tbin);

        for (n = 0; n < 20 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        a   = ta;
        b   = tb;
        bin = tbin;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        bin = 1'($urandom);

        for (lat = 0; lat < 20 && !out_valid; lat++) begin
            if (poke && lat == 1) begin
                in_valid = 1'b1;
                a   = ~ta;
                b   = ta;
                bin = ~tbin;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("latency", 32'(lat), 32'(NDIG));

        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("stall_diff",      32'(diff),      32'(e.diff));
            check("stall_bout",      32'(bout),      32'(e.bout));
            check("stall_ovf",       32'(ovf),       32'(e.ovf));
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end

        for (n = 0; n < 64 && out_valid; n++) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("handshake_done", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_flags",     32'({bout, ovf, zero}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0004, 1'b1, 0, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, 1'b0);

        // Backpressure plus ignored in_valid during CALC
        do_op(16'hA5C3, 16'h3C5A, 1'b1, 3, 1'b1, 1'b0);

        // Reset in the middle of CALC after two digits
        in_valid = 1'b1;
        a   = 16'hFFFF;
        b   = 16'h0001;
        bin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_diff",      32'(diff),      32'd0);
        check("midrst_flags",     32'({bout, ovf, zero}), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0, 1'b0);

        // Random operands with random consumer backpressure
        for (int i = 0; i < 1000; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b0, 1'b1);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_cla_subtractor
